// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the system controller: command opcodes, operand addresses
// and the controller state encoding.
package sys_ctrl_pkg;

    localparam logic [7:0] CMD_RF_WR    = 8'hAA;
    localparam logic [7:0] CMD_RF_RD    = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP   = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP  = 8'hDD;
    localparam logic [7:0] CMD_BURST_RD = 8'hBE;
    localparam logic [7:0] ERR_BYTE     = 8'hEE;

    localparam int unsigned OPA_ADDR = 32'd0;
    localparam int unsigned OPB_ADDR = 32'd1;

    typedef enum logic [4:0] {
        IDLE       = 5'd0,
        WAIT_ADDR  = 5'd1,
        WAIT_DATA  = 5'd2,
        RF_WR      = 5'd3,
        RF_RD_REQ  = 5'd4,
        RF_RD_WAIT = 5'd5,
        FIFO_PUSH  = 5'd6,
        WAIT_OPA   = 5'd7,
        WR_OPA     = 5'd8,
        WAIT_OPB   = 5'd9,
        WR_OPB     = 5'd10,
        WAIT_FUN   = 5'd11,
        ALU_CALC   = 5'd12,
        PUSH_LO    = 5'd13,
        PUSH_HI    = 5'd14,
        WAIT_CNT   = 5'd15,
        ERR_PUSH   = 5'd16
    } state_t;

    // States in which the controller is waiting for the next byte of a frame
    function automatic logic is_wait_state(input state_t s);
        case (s)
            WAIT_ADDR, WAIT_DATA, WAIT_OPA, WAIT_OPB, WAIT_FUN, WAIT_CNT: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sys_ctrl_burst_timeout.sv
// Inter-byte frame timeout: down-counter reloaded on load, decremented while enabled,
// expire flags an enabled cycle with the count already exhausted.
module frame_timeout_cnt #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic i_CLK,
    input  logic i_RST,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_r;

    // Count register: reload has priority over decrement
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= LOAD_VAL;
        end else if (en && (cnt_r != '0)) begin
            cnt_r <= cnt_r - CW'(1);
        end
    end

    assign expire = en && !load && (cnt_r == '0);

endmodule

// File: rtl/sys_ctrl_burst.sv
// System controller: decodes UART command frames into RegFile, ALU and TX FIFO traffic.
// Optional SYS_CTRL_ERR_RESP_EN: push 0xEE to the FIFO on frame errors and unknown commands.
module sys_ctrl_burst
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int ALU_FUN_WIDTH = 4,
    parameter int MAX_BURST     = 8,
    parameter int TIMEOUT_CYC   = 1024
) (
    input  logic                      i_CLK,
    input  logic                      i_RST,
    input  logic [DATA_WIDTH-1:0]     i_RX_P_DATA,
    input  logic                      i_RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]     i_RdData,
    input  logic                      i_RdData_Valid,
    input  logic [2*DATA_WIDTH-1:0]   i_ALU_OUT,
    input  logic                      i_OUT_Valid,
    input  logic                      i_FIFO_FULL,
    output logic [ADDR_WIDTH-1:0]     o_Address,
    output logic [DATA_WIDTH-1:0]     o_WrData,
    output logic                      o_WrEn,
    output logic                      o_RdEn,
    output logic [ALU_FUN_WIDTH-1:0]  o_ALU_FUN,
    output logic                      o_ALU_EN,
    output logic                      o_CLK_EN,
    output logic [DATA_WIDTH-1:0]     o_FIFO_DATA,
    output logic                      o_WR_INC,
    output logic                      o_clk_div_en,
    output logic                      o_busy,
    output logic                      o_frame_err
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [DATA_WIDTH-1:0] OP_WR    = DATA_WIDTH'(CMD_RF_WR);
    localparam logic [DATA_WIDTH-1:0] OP_RD    = DATA_WIDTH'(CMD_RF_RD);
    localparam logic [DATA_WIDTH-1:0] OP_ALU   = DATA_WIDTH'(CMD_ALU_OP);
    localparam logic [DATA_WIDTH-1:0] OP_NOP   = DATA_WIDTH'(CMD_ALU_NOP);
    localparam logic [DATA_WIDTH-1:0] OP_BURST = DATA_WIDTH'(CMD_BURST_RD);
    localparam logic [DATA_WIDTH-1:0] BURST_MAX_V = DATA_WIDTH'(MAX_BURST);
`ifdef SYS_CTRL_ERR_RESP_EN
    localparam state_t ERR_NEXT = ERR_PUSH;
`else
    localparam state_t ERR_NEXT = IDLE;
`endif

    state_t                    state_r, next_s;
    logic [DATA_WIDTH-1:0]     cmd_r, data_r, rd_r;
    logic [ADDR_WIDTH-1:0]     addr_r;
    logic [ALU_FUN_WIDTH-1:0]  fun_r;
    logic [CNT_W-1:0]          cnt_r;
    logic [2*DATA_WIDTH-1:0]   alu_r;
    logic                      err_s, err_r, tmo_expire_s, wait_s, cnt_bad_s;

    assign wait_s    = is_wait_state(state_r);
    assign cnt_bad_s = (i_RX_P_DATA == '0) || (i_RX_P_DATA > BURST_MAX_V);

    // Entering or leaving a wait state restarts the inter-byte window
    frame_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .i_CLK  (i_CLK),
        .i_RST  (i_RST),
        .load   (i_RX_D_VLD || !wait_s),
        .en     (wait_s),
        .expire (tmo_expire_s)
    );

    // State register
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_r <= IDLE;
            err_r   <= 1'b0;
        end else begin
            state_r <= next_s;
            err_r   <= err_s;
        end
    end

    // Next-state decode; a timeout in any wait state wins over a missing byte
    always_comb begin
        next_s = state_r;
        err_s  = 1'b0;
        if (wait_s && tmo_expire_s) begin
            err_s  = 1'b1;
            next_s = ERR_NEXT;
        end else begin
            case (state_r)
                IDLE: begin
                    if (i_RX_D_VLD) begin
                        case (i_RX_P_DATA)
                            OP_WR, OP_RD, OP_BURST: next_s = WAIT_ADDR;
                            OP_ALU:                 next_s = WAIT_OPA;
                            OP_NOP:                 next_s = WAIT_FUN;
                            default:                next_s = ERR_NEXT;
                        endcase
                    end else begin
                        next_s = IDLE;
                    end
                end
                WAIT_ADDR: begin
                    if (!i_RX_D_VLD)            next_s = WAIT_ADDR;
                    else if (cmd_r == OP_WR)    next_s = WAIT_DATA;
                    else if (cmd_r == OP_RD)    next_s = RF_RD_REQ;
                    else                        next_s = WAIT_CNT;
                end
                WAIT_DATA:  next_s = i_RX_D_VLD ? RF_WR  : WAIT_DATA;
                WAIT_OPA:   next_s = i_RX_D_VLD ? WR_OPA : WAIT_OPA;
                WAIT_OPB:   next_s = i_RX_D_VLD ? WR_OPB : WAIT_OPB;
                WAIT_FUN:   next_s = i_RX_D_VLD ? ALU_CALC : WAIT_FUN;
                WAIT_CNT: begin
                    if (!i_RX_D_VLD) begin
                        next_s = WAIT_CNT;
                    end else if (cnt_bad_s) begin
                        err_s  = 1'b1;
                        next_s = ERR_NEXT;
                    end else begin
                        next_s = RF_RD_REQ;
                    end
                end
                RF_WR:      next_s = IDLE;
                WR_OPA:     next_s = WAIT_OPB;
                WR_OPB:     next_s = WAIT_FUN;
                RF_RD_REQ:  next_s = RF_RD_WAIT;
                RF_RD_WAIT: next_s = i_RdData_Valid ? FIFO_PUSH : RF_RD_WAIT;
                FIFO_PUSH: begin
                    if (i_FIFO_FULL)        next_s = FIFO_PUSH;
                    else if (cnt_r != '0)   next_s = RF_RD_REQ;
                    else                    next_s = IDLE;
                end
                ALU_CALC:   next_s = i_OUT_Valid ? PUSH_LO : ALU_CALC;
                PUSH_LO:    next_s = i_FIFO_FULL ? PUSH_LO : PUSH_HI;
                PUSH_HI:    next_s = i_FIFO_FULL ? PUSH_HI : IDLE;
                ERR_PUSH:   next_s = i_FIFO_FULL ? ERR_PUSH : IDLE;
                default:    next_s = IDLE;
            endcase
        end
    end

    // Frame datapath: byte capture, burst address/count stepping, read and ALU results
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            cmd_r  <= '0;
            data_r <= '0;
            rd_r   <= '0;
            addr_r <= '0;
            fun_r  <= '0;
            cnt_r  <= '0;
            alu_r  <= '0;
        end else begin
            case (state_r)
                IDLE: if (i_RX_D_VLD) begin
                    cmd_r <= i_RX_P_DATA;
                    cnt_r <= '0;
                end
                WAIT_ADDR: if (i_RX_D_VLD) addr_r <= i_RX_P_DATA[ADDR_WIDTH-1:0];
                WAIT_DATA: if (i_RX_D_VLD) data_r <= i_RX_P_DATA;
                WAIT_OPA: if (i_RX_D_VLD) begin
                    data_r <= i_RX_P_DATA;
                    addr_r <= ADDR_WIDTH'(OPA_ADDR);
                end
                WAIT_OPB: if (i_RX_D_VLD) begin
                    data_r <= i_RX_P_DATA;
                    addr_r <= ADDR_WIDTH'(OPB_ADDR);
                end
                WAIT_FUN: if (i_RX_D_VLD) fun_r <= i_RX_P_DATA[ALU_FUN_WIDTH-1:0];
                WAIT_CNT: if (i_RX_D_VLD) cnt_r <= CNT_W'(i_RX_P_DATA - DATA_WIDTH'(1));
                RF_RD_WAIT: if (i_RdData_Valid) rd_r <= i_RdData;
                FIFO_PUSH: if (!i_FIFO_FULL && (cnt_r != '0)) begin
                    cnt_r  <= cnt_r - CNT_W'(1);
                    addr_r <= addr_r + ADDR_WIDTH'(1);
                end
                ALU_CALC: if (i_OUT_Valid) alu_r <= i_ALU_OUT;
                default: ;
            endcase
        end
    end

    // Output decode from the registered state; FIFO pushes are gated by full
    always_comb begin
        o_WrEn      = 1'b0;
        o_RdEn      = 1'b0;
        o_ALU_EN    = 1'b0;
        o_CLK_EN    = 1'b0;
        o_WR_INC    = 1'b0;
        o_FIFO_DATA = '0;
        case (state_r)
            RF_WR, WR_OPA, WR_OPB: o_WrEn = 1'b1;
            RF_RD_REQ:             o_RdEn = 1'b1;
            ALU_CALC: begin
                o_ALU_EN = 1'b1;
                o_CLK_EN = 1'b1;
            end
            FIFO_PUSH: begin
                o_FIFO_DATA = rd_r;
                o_WR_INC    = !i_FIFO_FULL;
            end
            PUSH_LO: begin
                o_FIFO_DATA = alu_r[DATA_WIDTH-1:0];
                o_WR_INC    = !i_FIFO_FULL;
            end
            PUSH_HI: begin
                o_FIFO_DATA = alu_r[2*DATA_WIDTH-1:DATA_WIDTH];
                o_WR_INC    = !i_FIFO_FULL;
            end
            ERR_PUSH: begin
                o_FIFO_DATA = DATA_WIDTH'(ERR_BYTE);
                o_WR_INC    = !i_FIFO_FULL;
            end
            default: ;
        endcase
    end

    assign o_Address    = addr_r;
    assign o_WrData     = data_r;
    assign o_ALU_FUN    = fun_r;
    assign o_busy       = (state_r != IDLE);
    assign o_frame_err  = err_r;
    assign o_clk_div_en = 1'b1;

endmodule

// File: tb/tb_sys_ctrl_burst.sv
// Randomised scoreboard bench for sys_ctrl_burst with RegFile, ALU and FIFO-full
// responders; a high-level command model predicts writes, FIFO bytes, reads and errors.
module tb_sys_ctrl_burst;

    localparam int TO = 64;

    logic        i_CLK = 1'b0;
    logic        i_RST;
    logic [7:0]  i_RX_P_DATA;
    logic        i_RX_D_VLD;
    logic [7:0]  i_RdData;
    logic        i_RdData_Valid;
    logic [15:0] i_ALU_OUT;
    logic        i_OUT_Valid;
    logic        i_FIFO_FULL;
    logic [3:0]  o_Address;
    logic [7:0]  o_WrData;
    logic        o_WrEn, o_RdEn;
    logic [3:0]  o_ALU_FUN;
    logic        o_ALU_EN, o_CLK_EN;
    logic [7:0]  o_FIFO_DATA;
    logic        o_WR_INC, o_clk_div_en, o_busy, o_frame_err;

    sys_ctrl_burst #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_FUN_WIDTH(4),
                     .MAX_BURST(8), .TIMEOUT_CYC(TO)) dut (
        .i_CLK(i_CLK), .i_RST(i_RST), .i_RX_P_DATA(i_RX_P_DATA), .i_RX_D_VLD(i_RX_D_VLD),
        .i_RdData(i_RdData), .i_RdData_Valid(i_RdData_Valid), .i_ALU_OUT(i_ALU_OUT),
        .i_OUT_Valid(i_OUT_Valid), .i_FIFO_FULL(i_FIFO_FULL), .o_Address(o_Address),
        .o_WrData(o_WrData), .o_WrEn(o_WrEn), .o_RdEn(o_RdEn), .o_ALU_FUN(o_ALU_FUN),
        .o_ALU_EN(o_ALU_EN), .o_CLK_EN(o_CLK_EN), .o_FIFO_DATA(o_FIFO_DATA),
        .o_WR_INC(o_WR_INC), .o_clk_div_en(o_clk_div_en), .o_busy(o_busy),
        .o_frame_err(o_frame_err)
    );

    always #5 i_CLK = ~i_CLK;

    int total = 0, bad = 0;
    int exp_rd = 0, obs_rd = 0, exp_err = 0, obs_err = 0, obs_push = 0;
    int cyc = 0, push_cyc = 0, gap_max = 0, rd_dly_min = 1, rd_dly_max = 3;
    bit rand_full_en = 1'b0, force_full = 1'b0;
    logic [7:0]  ref_rf [16];
    logic [7:0]  env_rf [16];
    logic [7:0]  exp_fifo [$];
    logic [11:0] exp_wr [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
        case (f[1:0])
            2'd0:    return {8'd0, a} + {8'd0, b};
            2'd1:    return {8'd0, a} - {8'd0, b};
            2'd2:    return {8'd0, a} * {8'd0, b};
            default: return {a, b};
        endcase
    endfunction

    initial forever begin
        @(posedge i_CLK);
        cyc++;
    end

    initial begin
        i_FIFO_FULL = 1'b0;
        forever begin
            @(posedge i_CLK);
            #1 i_FIFO_FULL = force_full || (rand_full_en && ($urandom_range(0, 3) == 0));
        end
    end

    // RegFile: writes land mid-cycle, reads return valid one or more cycles after RdEn
    initial forever begin
        @(negedge i_CLK);
        if (o_WrEn && !i_RST) env_rf[o_Address] = o_WrData;
    end

    initial begin
        logic [3:0] a;
        i_RdData_Valid = 1'b0;
        i_RdData = 8'd0;
        forever begin
            @(negedge i_CLK);
            if (o_RdEn && !i_RST) begin
                a = o_Address;
                repeat ($urandom_range(rd_dly_min, rd_dly_max)) @(negedge i_CLK);
                i_RdData = env_rf[a];
                i_RdData_Valid = 1'b1;
                @(negedge i_CLK);
                i_RdData_Valid = 1'b0;
            end
        end
    end

    initial begin
        i_OUT_Valid = 1'b0;
        i_ALU_OUT = 16'd0;
        forever begin
            @(negedge i_CLK);
            if (o_ALU_EN && !i_RST) begin
                repeat ($urandom_range(0, 2)) @(negedge i_CLK);
                i_ALU_OUT = alu(env_rf[0], env_rf[1], o_ALU_FUN);
                i_OUT_Valid = 1'b1;
                @(negedge i_CLK);
                i_OUT_Valid = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboards whenever the DUT presents a write or a push
    initial begin
        logic prev_err;
        prev_err = 1'b0;
        forever begin
            @(negedge i_CLK);
            if (!i_RST) begin
                if (o_WR_INC) begin
                    obs_push++;
                    push_cyc = cyc;
                    check("push_while_full", {31'd0, i_FIFO_FULL}, 32'd0);
                    if (exp_fifo.size() == 0) begin
                        total++; bad++;
                        $display("FAIL fifo_unexpected_push: got %0h expected none", o_FIFO_DATA);
                    end else begin
                        check("fifo_data", {24'd0, o_FIFO_DATA}, {24'd0, exp_fifo.pop_front()});
                    end
                end
                if (o_WrEn) begin
                    if (exp_wr.size() == 0) begin
                        total++; bad++;
                        $display("FAIL rf_unexpected_write: got addr %0h data %0h expected none", o_Address, o_WrData);
                    end else begin
                        check("rf_write", {20'd0, o_Address, o_WrData}, {20'd0, exp_wr.pop_front()});
                    end
                end
                if (o_RdEn) obs_rd++;
                if (o_frame_err) begin
                    obs_err++;
                    check("frame_err_one_cycle", {31'd0, prev_err}, 32'd0);
                end
                if (o_ALU_EN || o_CLK_EN) check("clk_en_vs_alu_en", {31'd0, o_CLK_EN}, {31'd0, o_ALU_EN});
            end
            prev_err = o_frame_err;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge i_CLK);
        #1;
        i_RX_P_DATA = b;
        i_RX_D_VLD = 1'b1;
        @(posedge i_CLK);
        #1 i_RX_D_VLD = 1'b0;
        repeat ($urandom_range(0, gap_max)) @(posedge i_CLK);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge i_CLK);
        while (o_busy && n < 3000) begin
            @(negedge i_CLK);
            n++;
        end
        check(name, {31'd0, (n < 3000)}, 32'd1);
        repeat (2) @(negedge i_CLK);
    endtask

    task automatic model_err();
        exp_err++;
`ifdef SYS_CTRL_ERR_RESP_EN
        exp_fifo.push_back(8'hEE);
`endif
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        exp_wr.push_back({a[3:0], d});
        ref_rf[a[3:0]] = d;
        send_byte(8'hAA); send_byte(a); send_byte(d);
        wait_idle("idle_after_write");
    endtask

    task automatic do_read(input logic [7:0] a);
        exp_rd++;
        exp_fifo.push_back(ref_rf[a[3:0]]);
        send_byte(8'hBB); send_byte(a);
        wait_idle("idle_after_read");
    endtask

    task automatic push_alu(input logic [15:0] r);
        exp_fifo.push_back(r[7:0]);
        exp_fifo.push_back(r[15:8]);
    endtask

    task automatic do_alu(input logic [7:0] x, input logic [7:0] y, input logic [3:0] f, input bit wait_done);
        exp_wr.push_back({4'd0, x});
        exp_wr.push_back({4'd1, y});
        ref_rf[0] = x;
        ref_rf[1] = y;
        push_alu(alu(x, y, f));
        send_byte(8'hCC); send_byte(x); send_byte(y); send_byte({4'd0, f});
        if (wait_done) wait_idle("idle_after_alu");
    endtask

    task automatic do_nop(input logic [3:0] f);
        push_alu(alu(ref_rf[0], ref_rf[1], f));
        send_byte(8'hDD); send_byte({4'd0, f});
        wait_idle("idle_after_nop");
    endtask

    task automatic do_burst(input logic [7:0] a, input logic [7:0] n);
        logic [3:0] ad;
        ad = a[3:0];
        if (n == 8'd0 || n > 8'd8) begin
            model_err();
        end else begin
            for (int i = 0; i < int'(n); i++) begin
                exp_rd++;
                exp_fifo.push_back(ref_rf[ad]);
                ad = ad + 4'd1;
            end
        end
        send_byte(8'hBE); send_byte(a); send_byte(n);
        wait_idle("idle_after_burst");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, e0, r0, n, s;
        logic [7:0] b;
        i_RST = 1'b1;
        i_RX_P_DATA = 8'd0;
        i_RX_D_VLD = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ref_rf[i] = 8'($urandom);
            env_rf[i] = ref_rf[i];
        end
        repeat (3) @(negedge i_CLK);
        check("reset_outputs_zero", {o_WrEn, o_RdEn, o_ALU_EN, o_CLK_EN, o_WR_INC, o_busy, o_frame_err,
              o_Address, o_WrData, o_ALU_FUN, o_FIFO_DATA}, 32'd0);
        check("reset_clk_div_en", {31'd0, o_clk_div_en}, 32'd1);
        @(posedge i_CLK);
        #1 i_RST = 1'b0;

        // Write then read back through the FIFO
        do_write(8'h05, 8'h3C);
        p0 = obs_push;
        do_read(8'h05);
        check("read_one_push", obs_push - p0, 32'd1);

        // ALU op with add: 0x12 + 0x34 = 0x0046
        do_alu(8'h12, 8'h34, 4'd0, 1'b1);

        // Burst wrapping E, F, 0 and an illegal zero count
        do_burst(8'h0E, 8'h03);
        r0 = obs_rd; e0 = obs_err;
        do_burst(8'h0E, 8'h00);
        check("bad_count_no_read", obs_rd - r0, 32'd0);
        check("bad_count_err", obs_err - e0, 32'd1);

        // FIFO full held across PUSH_LO
        force_full = 1'b1;
        do_alu(8'h21, 8'h03, 4'd2, 1'b0);
        n = 0;
        while (!o_ALU_EN && n < 200) begin @(negedge i_CLK); n++; end
        while (o_ALU_EN && n < 200) begin @(negedge i_CLK); n++; end
        check("stall_reached_push", {31'd0, (n < 200)}, 32'd1);
        p0 = obs_push;
        repeat (10) @(negedge i_CLK);
        check("stall_no_push", obs_push - p0, 32'd0);
        @(posedge i_CLK);
        #1 force_full = 1'b0;
        wait_idle("idle_after_stall");
        check("stall_two_pushes", obs_push - p0, 32'd2);

        // Timeout: command and address, then silence
        e0 = obs_err;
        model_err();
        send_byte(8'hAA); send_byte(8'h05);
        repeat (TO - 3) @(posedge i_CLK);
        @(negedge i_CLK);
        check("no_early_timeout", {31'd0, o_busy}, 32'd1);
        wait_idle("idle_after_timeout");
        check("timeout_err", obs_err - e0, 32'd1);
        do_read(8'h05);

        // Read latency: push lands in the third cycle after the address strobe cycle
        rd_dly_min = 1; rd_dly_max = 1;
        exp_rd++;
        exp_fifo.push_back(ref_rf[4'h9]);
        send_byte(8'hBB); send_byte(8'h09);
        s = cyc;
        wait_idle("idle_after_latency");
        check("read_latency", push_cyc - s, 32'd2);
        rd_dly_max = 3;

        // Randomised command mix
        rand_full_en = 1'b1;
        gap_max = 3;
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 6))
                0: do_write(8'($urandom), 8'($urandom));
                1: do_read(8'($urandom));
                2: do_alu(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), 1'b1);
                3: do_nop(4'($urandom_range(0, 15)));
                4: do_burst(8'($urandom), 8'($urandom_range(1, 8)));
                5: do_burst(8'($urandom), ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(9, 255)));
                default: begin
                    b = 8'($urandom);
                    while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD || b == 8'hBE) b = 8'($urandom);
`ifdef SYS_CTRL_ERR_RESP_EN
                    exp_fifo.push_back(8'hEE);
`endif
                    send_byte(b);
                    wait_idle("idle_after_unknown");
                end
            endcase
        end
        rand_full_en = 1'b0;
        gap_max = 0;

        // Reset asserted while waiting for read data of a burst
        rd_dly_min = 3; rd_dly_max = 3;
        exp_rd++;
        send_byte(8'hBE); send_byte(8'h03); send_byte(8'h04);
        n = 0;
        @(negedge i_CLK);
        while (!o_RdEn && n < 100) begin @(negedge i_CLK); n++; end
        check("burst_read_started", {31'd0, (n < 100)}, 32'd1);
        @(posedge i_CLK);
        #1 i_RST = 1'b1;
        #1;
        check("midburst_reset_outputs", {o_WrEn, o_RdEn, o_ALU_EN, o_CLK_EN, o_WR_INC, o_busy, o_frame_err,
              o_Address, o_WrData, o_ALU_FUN, o_FIFO_DATA}, 32'd0);
        check("midburst_reset_clk_div_en", {31'd0, o_clk_div_en}, 32'd1);
        repeat (2) @(posedge i_CLK);
        #1 i_RST = 1'b0;
        repeat (6) @(negedge i_CLK);
        check("idle_after_reset", {31'd0, o_busy}, 32'd0);
        rd_dly_min = 1;
        do_read(8'h03);

        check("fifo_queue_drained", exp_fifo.size(), 32'd0);
        check("write_queue_drained", exp_wr.size(), 32'd0);
        check("read_count", obs_rd, exp_rd);
        check("error_count", obs_err, exp_err);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
